// File: rtl/nubus_sram_pkg.sv
// Shared types and constants for the NuBus SRAM controller.
// Holds the access state encoding, byte-enable constants and a read/write helper.
package nubus_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    RELEASE
  } state_t;

  localparam logic [3:0] BEN_NONE = 4'hF;
  localparam logic [3:0] BEN_ALL  = 4'h0;

  // A request with no byte-lane write strobes is a read.
  function automatic logic is_read(input logic [3:0] write);
    return (write == 4'b0000);
  endfunction

endpackage

// File: rtl/nubus_sram_ctrl.sv
// NuBus slave memory port backend: turns mem_* requests into timed accesses
// on an external asynchronous 32-bit SRAM with byte enables and wait states.
module nubus_sram_ctrl #(
  parameter int          ADDR_W         = 18,
  parameter int          EXP_ENABLE     = 0,
  parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
) (
  input  logic              mem_clk,
  input  logic              mem_reset,
  input  logic              mem_valid,
  input  logic [3:0]        mem_write,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_myslot,
  input  logic              mem_myexp,
  input  logic [1:0]        mem_wait_clocks,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic [3:0]        sram_ben
);
  import nubus_sram_pkg::*;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [3:0]  r_write;
  logic        w_mapped;
  logic        w_unused_addr;

  assign w_mapped      = mem_myslot | ((EXP_ENABLE != 0) & mem_myexp);
  assign w_unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  // Every SRAM pin is set on entry to the state that needs it, so all outputs stay registered.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      r_state    <= IDLE;
      r_cnt      <= 2'd0;
      r_write    <= 4'b0000;
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'h0000_0000;
      sram_addr  <= '0;
      sram_dq_o  <= 32'h0000_0000;
      sram_dq_oe <= 1'b0;
      sram_cen   <= 1'b1;
      sram_oen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_ben   <= BEN_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_valid && w_mapped) begin
            r_write   <= mem_write;
            r_cnt     <= mem_wait_clocks;
            sram_addr <= mem_addr[ADDR_W+1:2];
            sram_cen  <= 1'b0;
            if (is_read(mem_write)) begin
              sram_oen <= 1'b0;
              sram_ben <= BEN_ALL;
            end else begin
              sram_dq_oe <= 1'b1;
              sram_dq_o  <= mem_wdata;
              sram_ben   <= ~mem_write;
            end
            r_state <= SETUP;
          end else if (mem_valid) begin
            if (is_read(mem_write)) begin
              mem_rdata <= UNMAPPED_RDATA;
            end
            mem_ready <= 1'b1;
            r_state   <= DONE;
          end
        end

        SETUP: begin
          if (!is_read(r_write)) begin
            sram_wen <= 1'b0;
          end
          r_state <= STROBE;
        end

        STROBE: begin
          if (r_cnt == 2'd0) begin
            if (is_read(r_write)) begin
              mem_rdata <= sram_dq_i;
              sram_cen  <= 1'b1;
              sram_oen  <= 1'b1;
              sram_ben  <= BEN_NONE;
              mem_ready <= 1'b1;
              r_state   <= DONE;
            end else begin
              sram_wen <= 1'b1;
              r_state  <= HOLD;
            end
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end

        // Write data and chip enable stay put one more cycle after wen rises.
        HOLD: begin
          sram_cen   <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_ben   <= BEN_NONE;
          mem_ready  <= 1'b1;
          r_state    <= DONE;
        end

        DONE: begin
          mem_ready <= 1'b0;
          r_state   <= RELEASE;
        end

        // The slave holds valid until it sees ready; wait for it to drop so it cannot re-trigger.
        RELEASE: begin
          if (!mem_valid) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nubus_sram_ctrl.sv
// Directed bench for nubus_sram_ctrl: one instance with expansion mapping off,
// one with it on, each driving a small behavioural SRAM.
module tb_nubus_sram_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid0, valid1;
  logic [3:0]  memWrite;
  logic [31:0] memAddr, memWdata;
  logic        mySlot, myExp;
  logic [1:0]  waitClocks;

  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1;
  logic [17:0] sramAddr0, sramAddr1;
  logic [31:0] dqO0, dqO1, dqI0, dqI1;
  logic        dqOe0, dqOe1, cen0, cen1, oen0, oen1, wen0, wen1;
  logic [3:0]  ben0, ben1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];

  int checks = 0;
  int failures = 0;
  int readyCnt0 = 0, cenCyc0 = 0, wenCyc0 = 0, oeViol = 0;
  int readyCnt1 = 0, cenCyc1 = 0;
  logic [3:0] benSeen0 = 4'hF;

  always #5 clock = ~clock;

  nubus_sram_ctrl #(.ADDR_W(18), .EXP_ENABLE(0), .UNMAPPED_RDATA(32'h0000_0000)) dut0 (
    .mem_clk(clock), .mem_reset(reset), .mem_valid(valid0), .mem_write(memWrite),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_myslot(mySlot), .mem_myexp(myExp),
    .mem_wait_clocks(waitClocks), .mem_rdata(rdata0), .mem_ready(ready0),
    .sram_addr(sramAddr0), .sram_dq_o(dqO0), .sram_dq_i(dqI0), .sram_dq_oe(dqOe0),
    .sram_cen(cen0), .sram_oen(oen0), .sram_wen(wen0), .sram_ben(ben0)
  );

  nubus_sram_ctrl #(.ADDR_W(18), .EXP_ENABLE(1), .UNMAPPED_RDATA(32'h0000_0000)) dut1 (
    .mem_clk(clock), .mem_reset(reset), .mem_valid(valid1), .mem_write(memWrite),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_myslot(mySlot), .mem_myexp(myExp),
    .mem_wait_clocks(waitClocks), .mem_rdata(rdata1), .mem_ready(ready1),
    .sram_addr(sramAddr1), .sram_dq_o(dqO1), .sram_dq_i(dqI1), .sram_dq_oe(dqOe1),
    .sram_cen(cen1), .sram_oen(oen1), .sram_wen(wen1), .sram_ben(ben1)
  );

  assign dqI0 = (!cen0 && !oen0) ? mem0[sramAddr0[7:0]] : 32'hDEAD_BEEF;
  assign dqI1 = (!cen1 && !oen1) ? mem1[sramAddr1[7:0]] : 32'hDEAD_BEEF;

  // SRAM models write per byte lane while strobed; activity counters sampled mid-cycle.
  always @(negedge clock) begin
    if (ready0) readyCnt0++;
    if (!cen0) cenCyc0++;
    if (dqOe0 && !oen0) oeViol++;
    if (!cen0 && !wen0) begin
      wenCyc0++;
      benSeen0 = ben0;
      for (int b = 0; b < 4; b++)
        if (!ben0[b]) mem0[sramAddr0[7:0]][8*b +: 8] = dqO0[8*b +: 8];
    end
    if (ready1) readyCnt1++;
    if (!cen1) cenCyc1++;
    if (dqOe1 && !oen1) oeViol++;
    if (!cen1 && !wen1) begin
      for (int b = 0; b < 4; b++)
        if (!ben1[b]) mem1[sramAddr1[7:0]][8*b +: 8] = dqO1[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Issues one request and returns the accept-to-ready latency in cycles.
  task automatic applyStimulus(input int sel, input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wd, input logic slot, input logic exp,
                               input logic [1:0] wt, input int hold, output int lat);
    int n;
    logic rdy;
    @(negedge clock);
    memAddr = addr; memWrite = we; memWdata = wd;
    mySlot = slot; myExp = exp; waitClocks = wt;
    if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(posedge clock);
      #1;
      n++;
      rdy = (sel == 0) ? ready0 : ready1;
      waitClocks = ~wt;
    end
    if (!rdy) checkOutput("ready_timeout", {31'b0, rdy}, 32'd1);
    if (hold > 0) begin
      repeat (hold) @(posedge clock);
      #1;
    end
    if (sel == 0) valid0 = 1'b0; else valid1 = 1'b0;
    repeat (3) @(posedge clock);
    lat = n;
  endtask

  initial begin
    int lat, r0, c0, c1, w0;
    logic [3:0]  laneWe  [3];
    logic [31:0] laneExp [3];
    laneWe  = '{4'b0001, 4'b0100, 4'b1100};
    laneExp = '{32'h0000_0021, 32'h0065_0000, 32'h8765_0000};
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
    reset = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    memWrite = 4'h0; memAddr = 32'h0; memWdata = 32'h0;
    mySlot = 1'b0; myExp = 1'b0; waitClocks = 2'd0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_strobes", {28'b0, cen0, oen0, wen0, dqOe0}, 32'hE);
    checkOutput("rst_ben", {28'b0, ben0}, 32'hF);
    checkOutput("rst_ready", {31'b0, ready0}, 32'd0);
    checkOutput("rst_rdata", rdata0, 32'h0);
    checkOutput("rst_addr_dq", {14'b0, sramAddr0} | dqO0, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Full-word write then readback, one wait state.
    w0 = wenCyc0;
    applyStimulus(0, 32'hF000_0000, 4'hF, 32'h8765_4321, 1'b1, 1'b0, 2'd1, 0, lat);
    checkOutput("wr_latency_w1", 32'(lat), 32'd5);
    checkOutput("wr_wen_cycles", 32'(wenCyc0 - w0), 32'd2);
    checkOutput("wr_mem_word0", mem0[0], 32'h8765_4321);
    applyStimulus(0, 32'hF000_0000, 4'h0, 32'h0, 1'b1, 1'b0, 2'd1, 0, lat);
    checkOutput("rd_latency_w1", 32'(lat), 32'd4);
    checkOutput("rd_data_word0", rdata0, 32'h8765_4321);

    // Byte-lane writes into zeroed words.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'(8 + 4*i), 4'hF, 32'h0, 1'b1, 1'b0, 2'd0, 0, lat);
      applyStimulus(0, 32'(8 + 4*i), laneWe[i], 32'h8765_4321, 1'b1, 1'b0, 2'd0, 0, lat);
      checkOutput("lane_wr_latency", 32'(lat), 32'd4);
      checkOutput("lane_ben", {28'b0, benSeen0}, {28'b0, ~laneWe[i]});
      applyStimulus(0, 32'(8 + 4*i), 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 0, lat);
      checkOutput("lane_readback", rdata0, laneExp[i]);
    end

    // Wait-state sweep on reads.
    for (int w = 0; w < 4; w++) begin
      r0 = readyCnt0;
      applyStimulus(0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 2'(w), 0, lat);
      checkOutput("sweep_latency", 32'(lat), 32'(3 + w));
      checkOutput("sweep_one_ready", 32'(readyCnt0 - r0), 32'd1);
      checkOutput("sweep_data", rdata0, 32'h8765_4321);
    end

    // Expansion-space request: unmapped on dut0, mapped on dut1.
    c0 = cenCyc0;
    applyStimulus(0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 2'd2, 0, lat);
    checkOutput("unmapped_latency", 32'(lat), 32'd1);
    checkOutput("unmapped_no_cen", 32'(cenCyc0 - c0), 32'd0);
    checkOutput("unmapped_rdata", rdata0, 32'h0);
    c1 = cenCyc1;
    applyStimulus(1, 32'h20, 4'hF, 32'hA5A5_5A5A, 1'b0, 1'b1, 2'd0, 0, lat);
    checkOutput("exp_wr_latency", 32'(lat), 32'd4);
    applyStimulus(1, 32'h20, 4'h0, 32'h0, 1'b0, 1'b1, 2'd0, 0, lat);
    checkOutput("exp_rd_latency", 32'(lat), 32'd3);
    checkOutput("exp_rd_data", rdata1, 32'hA5A5_5A5A);
    checkOutput("exp_cen_cycles", 32'(cenCyc1 - c1), 32'd5);

    // Valid held past ready must not start a second access.
    r0 = readyCnt0;
    c0 = cenCyc0;
    applyStimulus(0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 3, lat);
    checkOutput("stale_latency", 32'(lat), 32'd3);
    checkOutput("stale_one_ready", 32'(readyCnt0 - r0), 32'd1);
    checkOutput("stale_cen_cycles", 32'(cenCyc0 - c0), 32'd2);
    applyStimulus(0, 32'h8, 4'h0, 32'h0, 1'b1, 1'b0, 2'd0, 0, lat);
    checkOutput("after_stale_latency", 32'(lat), 32'd3);
    checkOutput("after_stale_data", rdata0, 32'h0000_0021);

    // Reset in the middle of a write strobe.
    @(negedge clock);
    memAddr = 32'h14; memWrite = 4'hF; memWdata = 32'h1111_2222;
    mySlot = 1'b1; myExp = 1'b0; waitClocks = 2'd3;
    valid0 = 1'b1;
    r0 = readyCnt0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_in_strobe", {31'b0, wen0}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_strobes", {29'b0, cen0, wen0, dqOe0}, 32'd6);
    valid0 = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    checkOutput("abort_no_ready", 32'(readyCnt0 - r0), 32'd0);
    applyStimulus(0, 32'h18, 4'hF, 32'h0BAD_F00D, 1'b1, 1'b0, 2'd2, 0, lat);
    checkOutput("post_abort_wr_latency", 32'(lat), 32'd6);
    applyStimulus(0, 32'h18, 4'h0, 32'h0, 1'b1, 1'b0, 2'd2, 0, lat);
    checkOutput("post_abort_rd_latency", 32'(lat), 32'd5);
    checkOutput("post_abort_rd_data", rdata0, 32'h0BAD_F00D);

    checkOutput("dq_driven_during_read", 32'(oeViol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
